// File: rtl/decode_stage_pipelined_pkg.sv
// Shared decode definitions for the pipelined decode stage: instruction classes,
// function codes, field bit positions and the registered ID/EX control bundle.
package decode_stage_pipelined_pkg;

  typedef enum logic [1:0] {
    FT_REG    = 2'b00,
    FT_MEM    = 2'b01,
    FT_BRANCH = 2'b10,
    FT_KERNEL = 2'b11
  } funtype_e;

  localparam logic [1:0] FC_MOV     = 2'b10;
  localparam logic [1:0] FC_CMP     = 2'b11;
  localparam logic [1:0] FC_LOAD    = 2'b00;
  localparam logic [1:0] FC_STORE   = 2'b01;
  localparam logic [1:0] FC_KSYS    = 2'b00;
  localparam logic [1:0] FC_CACHEWR = 2'b10;

  localparam int FUNTYPE_HI = 31;
  localparam int FUNCODE_HI = 29;
  localparam int RD_HI      = 27;
  localparam int RS_HI      = 23;
  localparam int RX_HI      = 19;
  localparam int SELIMM_BIT = 0;
  localparam int IMM4_HI    = 23;
  localparam int IMM4_LO    = 20;
  localparam int IMM19_HI   = 19;
  localparam int IMM19_LO   = 1;
  localparam int IMM28_HI   = 27;

  typedef struct packed {
    logic [3:0] rd;
    funtype_e   funtype;
    logic [1:0] funcode;
    logic       sel_wb;
    logic       sel_memrd;
    logic       sel_memwr;
    logic       sel_cachewr;
    logic       sel_branch;
  } id_ex_bundle_t;

  function automatic id_ex_bundle_t decode_ctrl(input logic [1:0] ft_bits,
                                                input logic [1:0] fc_bits,
                                                input logic [3:0] rd_bits);
    id_ex_bundle_t b;
    b.rd          = rd_bits;
    b.funtype     = funtype_e'(ft_bits);
    b.funcode     = fc_bits;
    b.sel_memrd   = (b.funtype == FT_MEM) && (fc_bits == FC_LOAD);
    b.sel_memwr   = (b.funtype == FT_MEM) && (fc_bits == FC_STORE);
    b.sel_cachewr = (b.funtype == FT_KERNEL) && (fc_bits == FC_CACHEWR);
    b.sel_branch  = (b.funtype == FT_BRANCH);
    b.sel_wb      = ((b.funtype == FT_REG) && (fc_bits != FC_CMP)) || b.sel_memrd ||
                    b.sel_branch || ((b.funtype == FT_KERNEL) && (fc_bits == FC_KSYS));
    return b;
  endfunction

endpackage

// File: rtl/decode_stage_pipelined_regfile.sv
// Flop-based register bank for the decode stage: NUM_REGS x BUS, three read ports,
// one write port, same-cycle write-through bypass; out-of-range addresses read 0.
module decode_regfile #(
  parameter int BUS      = 32,
  parameter int NUM_REGS = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wb_en,
  input  logic [3:0]     wb_addr,
  input  logic [BUS-1:0] wb_data,
  input  logic [3:0]     raddr_a,
  input  logic [3:0]     raddr_b,
  input  logic [3:0]     raddr_c,
  output logic [BUS-1:0] rdata_a,
  output logic [BUS-1:0] rdata_b,
  output logic [BUS-1:0] rdata_c
);

  logic [BUS-1:0] regs [NUM_REGS];

  // NOTE: this bank is built from flops, so it can take a reset; a RAM macro could not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      // NOTE: non-blocking, so every flop in the design samples pre-edge values.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_addr == 4'(i)) regs[i] <= wb_data;
      end
    end
  end

  // NOTE: defaults first, so no path leaves an output unassigned (no inferred latch).
  always_comb begin
    rdata_a = '0;
    rdata_b = '0;
    rdata_c = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (raddr_a == 4'(i)) rdata_a = (wb_en && wb_addr == 4'(i)) ? wb_data : regs[i];
      if (raddr_b == 4'(i)) rdata_b = (wb_en && wb_addr == 4'(i)) ? wb_data : regs[i];
      if (raddr_c == 4'(i)) rdata_c = (wb_en && wb_addr == 4'(i)) ? wb_data : regs[i];
    end
  end

endmodule

// File: rtl/decode_stage_pipelined.sv
// Registered decode stage: decode, operand read with bypass, load-use scoreboard and
// a valid/ready ID/EX bundle. Define DECODE_PERF_EN to add stall/issue counters.
module decode_stage_pipelined
  import decode_stage_pipelined_pkg::*;
#(
  parameter int             BUS          = 32,
  parameter int             NUM_REGS     = 16,
  parameter logic [BUS-1:0] RESET_PC_OUT = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [31:0]    instruction,
  input  logic [BUS-1:0] pc_in,
  input  logic           wb_en,
  input  logic [3:0]     wb_addr,
  input  logic [BUS-1:0] wb_data,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [BUS-1:0] opa,
  output logic [BUS-1:0] opb,
  output logic [BUS-1:0] str_data,
  output logic [BUS-1:0] pc_out,
  output logic [3:0]     rd,
  output logic [1:0]     funtype,
  output logic [1:0]     funcode,
  output logic           sel_wb,
  output logic           sel_memrd,
  output logic           sel_memwr,
  output logic           sel_cachewr,
  output logic           sel_branch
`ifdef DECODE_PERF_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    issued
`endif
);

  id_ex_bundle_t  dec, out_q;
  logic [3:0]     rd_f, rs_f, rx_f, rs_src;
  logic           selimm, is_cmp, is_mov, is_store;
  logic [BUS-1:0] imm, rdata_a, rdata_b, rdata_c, opa_d, opb_d;
  logic [BUS-1:0] opa_q, opb_q, str_q, pc_q;
  logic [15:0]    sb, sb_d, busy;
  logic           hazard, fire;

  always_comb begin
    dec      = decode_ctrl(instruction[FUNTYPE_HI -: 2], instruction[FUNCODE_HI -: 2],
                           instruction[RD_HI -: 4]);
    rd_f     = instruction[RD_HI -: 4];
    rs_f     = instruction[RS_HI -: 4];
    rx_f     = instruction[RX_HI -: 4];
    selimm   = instruction[SELIMM_BIT];
    is_cmp   = (dec.funtype == FT_REG) && (dec.funcode == FC_CMP);
    is_mov   = (dec.funtype == FT_REG) && (dec.funcode == FC_MOV);
    is_store = dec.sel_memwr;
    rs_src   = is_cmp ? rd_f : rs_f;
    if (dec.sel_cachewr)            imm = BUS'(instruction[IMM4_HI:IMM4_LO]);
    else if (dec.funtype == FT_REG) imm = BUS'(instruction[IMM19_HI:IMM19_LO]);
    else                            imm = BUS'(instruction[IMM28_HI:0]);
    opa_d = (is_mov || dec.funtype == FT_KERNEL) ? '0 : rdata_a;
    opb_d = (selimm || dec.sel_cachewr) ? imm : rdata_b;
  end

  decode_regfile #(.BUS(BUS), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .raddr_a (rs_src),
    .raddr_b (rx_f),
    .raddr_c (rd_f),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .rdata_c (rdata_c)
  );

  // A register is busy while a load to it is pending in the scoreboard (unless this
  // cycle's write-back retires it) or still sits in the output bundle.
  always_comb begin
    busy = sb & ~(wb_en ? (16'd1 << wb_addr) : 16'd0);
    if (out_valid && out_q.sel_memrd) busy[out_q.rd] = 1'b1;
    hazard   = busy[rs_src] | (~selimm & busy[rx_f]) |
               ((is_store | dec.sel_memrd) & busy[rd_f]);
    in_ready = ~hazard & (~out_valid | out_ready);
    fire     = in_valid & in_ready & ~flush;
  end

  // Set is applied after clear so a same-cycle set of the same bit wins.
  always_comb begin
    sb_d = sb;
    if (wb_en) sb_d[wb_addr] = 1'b0;
    if (out_valid && out_ready && out_q.sel_memrd) sb_d[out_q.rd] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb        <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      str_q     <= '0;
      pc_q      <= RESET_PC_OUT;
    end else begin
      sb <= sb_d;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (fire) begin
        out_valid <= 1'b1;
        out_q     <= dec;
        opa_q     <= opa_d;
        opb_q     <= opb_d;
        str_q     <= rdata_c;
        pc_q      <= pc_in + opb_d;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign opa         = opa_q;
  assign opb         = opb_q;
  assign str_data    = str_q;
  assign pc_out      = pc_q;
  assign rd          = out_q.rd;
  assign funtype     = out_q.funtype;
  assign funcode     = out_q.funcode;
  assign sel_wb      = out_q.sel_wb;
  assign sel_memrd   = out_q.sel_memrd;
  assign sel_memwr   = out_q.sel_memwr;
  assign sel_cachewr = out_q.sel_cachewr;
  assign sel_branch  = out_q.sel_branch;

`ifdef DECODE_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      issued       <= '0;
    end else begin
      if (in_valid && hazard && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (fire && issued != '1) issued <= issued + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Self-checking bench for decode_stage_pipelined: table-driven vectors with a
// scoreboard queue, plus hand sequences for reset, load-use, backpressure and flush.
module tb_decode_stage_pipelined;

  typedef struct {
    int          tag;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] str;
    logic [31:0] pco;
    logic [3:0]  rd;
    logic [1:0]  ft;
    logic [1:0]  fc;
    logic [4:0]  flags;  // {wb, memrd, memwr, cachewr, branch}
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] instruction, pc_in;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush, out_valid, out_ready;
  logic [31:0] opa, opb, str_data, pc_out;
  logic [3:0]  rd;
  logic [1:0]  funtype, funcode;
  logic        sel_wb, sel_memrd, sel_memwr, sel_cachewr, sel_branch;
`ifdef DECODE_PERF_EN
  logic [31:0] stall_cycles, issued;
`endif

  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t q[$];
  vec_t tbl[10];
  vec_t zero;
  vec_t ld_v, add_r4_v, add_imm_r4_v, mov_v;

  always #5 clk = ~clk;

  decode_stage_pipelined #(.BUS(32), .NUM_REGS(12), .RESET_PC_OUT(32'h0000_00A0)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .pc_in       (pc_in),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opa         (opa),
    .opb         (opb),
    .str_data    (str_data),
    .pc_out      (pc_out),
    .rd          (rd),
    .funtype     (funtype),
    .funcode     (funcode),
    .sel_wb      (sel_wb),
    .sel_memrd   (sel_memrd),
    .sel_memwr   (sel_memwr),
    .sel_cachewr (sel_cachewr),
    .sel_branch  (sel_branch)
`ifdef DECODE_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .issued      (issued)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int tag, input logic [31:0] instr, input logic [31:0] pc,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] s,
                              input logic [31:0] pco, input logic [3:0] r, input logic [1:0] ft,
                              input logic [1:0] fc, input logic [4:0] flags);
    vec_t v;
    v.tag = tag; v.instr = instr; v.pc = pc; v.opa = a; v.opb = b; v.str = s;
    v.pco = pco; v.rd = r; v.ft = ft; v.fc = fc; v.flags = flags;
    return v;
  endfunction

  task automatic pop_compare();
    vec_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL unexpected_bundle: got rd=%h opa=%h with no bundle expected", rd, opa);
    end else begin
      e = q.pop_front();
      check($sformatf("v%0d_opa", e.tag), opa, e.opa);
      check($sformatf("v%0d_opb", e.tag), opb, e.opb);
      check($sformatf("v%0d_str", e.tag), str_data, e.str);
      check($sformatf("v%0d_pc", e.tag), pc_out, e.pco);
      check($sformatf("v%0d_rd", e.tag), 32'(rd), 32'(e.rd));
      check($sformatf("v%0d_ft", e.tag), 32'(funtype), 32'(e.ft));
      check($sformatf("v%0d_fc", e.tag), 32'(funcode), 32'(e.fc));
      check($sformatf("v%0d_flags", e.tag),
            32'({sel_wb, sel_memrd, sel_memwr, sel_cachewr, sel_branch}), 32'(e.flags));
    end
  endtask

  // One clock: drive at the falling edge, settle, then account for what the
  // coming rising edge will do (bundle accepted, bundle killed, instruction fired).
  task automatic cycle(input logic v, input vec_t e, input logic ordy, input logic fl,
                       input logic wbe, input logic [3:0] wba, input logic [31:0] wbd);
    @(negedge clk);
    in_valid = v; instruction = e.instr; pc_in = e.pc; out_ready = ordy; flush = fl;
    wb_en = wbe; wb_addr = wba; wb_data = wbd;
    #1;
    if (out_valid && out_ready && !flush) pop_compare();
    else if (out_valid && flush && q.size() > 0) void'(q.pop_front());
    if (in_valid && in_ready && !flush) q.push_back(e);
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, zero, ordy, 1'b0, 1'b0, 4'd0, 32'd0);
  endtask

  task automatic wb(input logic [3:0] a, input logic [31:0] d);
    cycle(1'b0, zero, 1'b1, 1'b0, 1'b1, a, d);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    zero = mk(99, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 2'd0, 2'd0, 5'd0);
    // Bank state for the table: R2=7, R5=0x55, R6=0x600, R13 out of range, rest 0.
    tbl[0] = mk(0, 32'h0120_000B, 32'h000, 32'h7,  32'h5,   32'h0,  32'h5,   4'd1, 2'd0, 2'd0, 5'b10000);
    tbl[1] = mk(1, 32'h1756_0000, 32'h020, 32'h55, 32'h600, 32'h0,  32'h620, 4'd7, 2'd0, 2'd1, 5'b10000);
    tbl[2] = mk(2, 32'h2850_0007, 32'h040, 32'h0,  32'h3,   32'h0,  32'h43,  4'd8, 2'd0, 2'd2, 5'b10000);
    tbl[3] = mk(3, 32'h3205_0000, 32'h000, 32'h7,  32'h55,  32'h7,  32'h55,  4'd2, 2'd0, 2'd3, 5'b00000);
    tbl[4] = mk(4, 32'h5520_0041, 32'h000, 32'h7,  32'h5200041, 32'h55, 32'h5200041, 4'd5, 2'd1, 2'd1, 5'b00100);
    tbl[5] = mk(5, 32'h8000_0011, 32'h100, 32'h0,  32'h11,  32'h0,  32'h111, 4'd0, 2'd2, 2'd0, 5'b10001);
    tbl[6] = mk(6, 32'h9006_0000, 32'h100, 32'h0,  32'h600, 32'h0,  32'h700, 4'd0, 2'd2, 2'd1, 5'b10001);
    tbl[7] = mk(7, 32'hE1A0_0000, 32'h010, 32'h0,  32'hA,   32'h0,  32'h1A,  4'd1, 2'd3, 2'd2, 5'b00010);
    tbl[8] = mk(8, 32'hC300_0001, 32'h000, 32'h0,  32'h3000001, 32'h0, 32'h3000001, 4'd3, 2'd3, 2'd0, 5'b10000);
    tbl[9] = mk(9, 32'h11D5_0000, 32'h000, 32'h0,  32'h55,  32'h0,  32'h55,  4'd1, 2'd0, 2'd1, 5'b10000);
    ld_v         = mk(20, 32'h4400_0001, 32'h0, 32'h0, 32'h4000001, 32'h0, 32'h4000001, 4'd4, 2'd1, 2'd0, 5'b11000);
    mov_v        = mk(21, 32'h2850_0007, 32'h0, 32'h0, 32'h3, 32'h0, 32'h3, 4'd8, 2'd0, 2'd2, 5'b10000);
    add_r4_v     = mk(22, 32'h0143_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 4'd1, 2'd0, 2'd0, 5'b10000);
    add_imm_r4_v = mk(23, 32'h0940_0005, 32'h0, 32'h1234, 32'h2, 32'h0, 32'h2, 4'd9, 2'd0, 2'd0, 5'b10000);

    rst = 1'b1; in_valid = 1'b0; instruction = '0; pc_in = '0; out_ready = 1'b0;
    flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pc_out", pc_out, 32'hA0);
    check("rst_opa", opa, 32'd0);
    check("rst_flags", 32'({sel_wb, sel_memrd, sel_memwr, sel_cachewr, sel_branch}), 32'd0);
    rst = 1'b0;

    // Reset mid-transfer and mid-stall: load R4 retires into the scoreboard,
    // a MOV is held, and an ADD reading R4 is stalled when reset hits.
    wb(4'd3, 32'h33);
    cycle(1'b1, ld_v, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    cycle(1'b1, mov_v, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    cycle(1'b1, add_r4_v, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    check("pre_rst_stall_ready", 32'(in_ready), 32'd0);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_pc_out", pc_out, 32'hA0);
    q.delete();
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    cycle(1'b1, add_r4_v, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    check("post_rst_sb_clear", 32'(in_ready), 32'd1);
    idle(1'b1);

    // Table vectors, back-to-back.
    wb(4'd2, 32'h7);
    wb(4'd5, 32'h55);
    wb(4'd6, 32'h600);
    wb(4'd13, 32'hDEAD);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, tbl[i], 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
      check($sformatf("tput_ready_%0d", i), 32'(in_ready), 32'd1);
    end
    idle(1'b1);
    idle(1'b1);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Load-use: ADD reading R4 waits for the write-back and takes the bypassed value.
    cycle(1'b1, ld_v, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, add_imm_r4_v, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
      check($sformatf("lu_stall_%0d", i), 32'(in_ready), 32'd0);
    end
    cycle(1'b1, add_imm_r4_v, 1'b1, 1'b0, 1'b1, 4'd4, 32'h1234);
    check("lu_wb_release", 32'(in_ready), 32'd1);
    idle(1'b1);

    // Backpressure: bundle held for 3 cycles, then back-to-back on release.
    cycle(1'b1, tbl[0], 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, tbl[1], 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
      check($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd0);
      check($sformatf("bp_valid_%0d", i), 32'(out_valid), 32'd1);
      check($sformatf("bp_opa_%0d", i), opa, 32'h7);
      check($sformatf("bp_opb_%0d", i), opb, 32'h5);
    end
    cycle(1'b1, tbl[1], 1'b1, 1'b0, 1'b0, 4'd0, 32'd0);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    idle(1'b1);

    // Flush kills the held bundle and drops the incoming instruction.
    cycle(1'b1, tbl[0], 1'b0, 1'b0, 1'b0, 4'd0, 32'd0);
    cycle(1'b1, tbl[1], 1'b0, 1'b1, 1'b0, 4'd0, 32'd0);
    idle(1'b1);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    idle(1'b1);
    check("flush_not_issued", 32'(out_valid), 32'd0);

    check("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage_pipelined.md
Name: decode_stage_pipelined

Overview:
- Parametrised, registered successor to the combinational instruction decoder.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes FUNTYPE/FUNCODE, RD/RS/RX and the immediates.
- Reads operands from an internal register bank with write-back bypass, stalls on load-use hazards through a per-register scoreboard, and presents a registered ID/EX bundle to execute.
- Supports a one-cycle flush from branch resolution.

Parameters:
- BUS, 32, datapath width; all immediates are zero-extended to BUS.
- NUM_REGS, 16, implemented registers, 2..16. Addresses >= NUM_REGS read 0 and ignore writes.
- RESET_PC_OUT, 0, reset value of pc_out.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept
- instruction  in  32  encoded instruction
- pc_in  in  BUS  PC of instruction
- wb_en  in  1  write-back strobe
- wb_addr  in  4  write-back register
- wb_data  in  BUS  write-back value
- flush  in  1  kill held bundle and incoming instruction
- out_valid  out  1  bundle valid
- out_ready  in  1  execute accepts
- opa, opb, str_data, pc_out  out  BUS  operands, store data, branch target
- rd  out  4  destination
- funtype, funcode  out  2  decoded class and function
- sel_wb, sel_memrd, sel_memwr, sel_cachewr, sel_branch  out  1  control flags

Behaviour:
- Field map:
  - FUNTYPE [31:30], FUNCODE [29:28], RD [27:24], RS [23:20], RX [19:16], selimm [0].
  - Imm4 = [23:20]. Imm19 = [19:1]. Imm28 = [27:0].
  - Reg class uses Imm19, others use Imm28, cache-write uses Imm4.
- Flag equations:
  - sel_wb = reg class except CMP(11), or load (01/00), or branch, or kernel 00.
  - sel_memrd = 01/00. sel_memwr = 01/01. sel_cachewr = 11/10. sel_branch = FUNTYPE 10.
- Operands:
  - The RS source is RD for CMP.
  - opa = 0 for MOV (00/10) and kernel class.
  - opb = immediate when selimm or sel_cachewr; otherwise the bank value of RX.
  - str_data = bank value of RD.
  - pc_out = pc_in + opb (BUS-bit wrap).
- Register bank:
  - Write occurs on the rising edge when wb_en.
  - A same-cycle read of wb_addr returns wb_data (write-through bypass).
- Hazard, evaluated combinationally:
  - Applies to each source actually used: RS, RX if not selimm, RD for stores.
  - hazard when (sb[src] & ~(wb_en & wb_addr==src)), or (out_valid & out sel_memrd & out rd==src).
  - A load whose RD is already pending is a WAW hazard and also stalls.
- Handshake:
  - in_ready = ~hazard & (~out_valid | out_ready).
  - fire = in_valid & in_ready & ~flush.
  - On fire the output register loads and out_valid=1.
  - If out_valid & out_ready & ~fire, out_valid clears.
  - The output bundle is held stable while out_valid & ~out_ready.
- Scoreboard:
  - sb[rd] is set when a load bundle is accepted by execute (out_valid & out_ready & sel_memrd).
  - sb[wb_addr] clears on wb_en.
  - Simultaneous set and clear of the same bit: set wins.
- Flush: out_valid clears next edge, the incoming instruction is dropped, the scoreboard is untouched.
- Latency: 1 cycle from fire to out_valid. Throughput: 1 instruction per cycle without hazards.
- Reset (asynchronous):
  - out_valid=0, sb=0, registers=0, pc_out=RESET_PC_OUT.
  - All other outputs = 0.
  - in_ready reflects reset state (1) while rst is high.
  - A reset mid-stall discards everything.

Optional Feature:
- DECODE_PERF_EN, when defined, adds:
  - Output ports stall_cycles and issued, each 32 bits.
  - stall_cycles increments each cycle with in_valid & hazard.
  - issued increments on each fire.
  - Both saturate at all ones and clear on rst.
- Without the macro, the ports and counters do not exist.

Decomposition:
- Shared package (extends ProcessorStructs): FUNTYPE/FUNCODE enum constants, the field bit positions, and an id_ex_bundle_t struct.
- Sub-module decode_regfile: NUM_REGS x BUS registers, 3 read ports, 1 write port, bypass.

Test Plan:
- Reset high mid-transfer -> out_valid=0, in_ready=1, scoreboard cleared. Read of R3 after reset -> 0.
- ADD R1,R2,imm 5 (selimm) with R2=7 -> next cycle out_valid=1, opa=7, opb=5, rd=1, sel_wb=1.
- Load R4 accepted by execute, then ADD using R4 -> in_ready=0 until wb_en with wb_addr=4. On that cycle opa equals wb_data=0x1234 and the ADD fires.
- out_ready=0 for 3 cycles with bundle held -> outputs unchanged, in_ready=0. Releasing out_ready gives back-to-back fire.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, the instruction is not issued.
- Branch with Imm28=0x10 and pc_in=0x100 -> pc_out=0x110, sel_branch=1, sel_wb=1.
